// File: rtl/alu32_issue.sv
// +-----------------------------------------------------------------------+
// | alu32_issue: command FIFO + issue FSM for a registered 32-bit ALU      |
// | Rev 1.0  initial release                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module alu32_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [3:0]       cmd_sel,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_sel,
  input  logic [31:0]      alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err,
  output logic             busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 68 + TAG_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAPT = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  state_t           state_q, state_d;
  logic [TAG_W-1:0] tag_lat_q, tag_lat_d;
  logic             ill_q, ill_d;
  logic             res_valid_q, res_valid_d;
  logic [31:0]      res_data_q, res_data_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic             res_err_q, res_err_d;

  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;
  logic [31:0]      head_a;
  logic [31:0]      head_b;
  logic [3:0]       head_sel;
  logic [TAG_W-1:0] head_tag;
  logic             head_ill;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;

  assign head     = mem_q[rd_ptr_q];
  assign head_a   = head[ENT_W-1 -: 32];
  assign head_b   = head[ENT_W-33 -: 32];
  assign head_sel = head[TAG_W+3 -: 4];
  assign head_tag = head[TAG_W-1:0];
  assign head_ill = (head_sel > 4'b0010);

  // The ALU registers these at the same edge the head is popped.
  assign alu_a   = empty ? 32'h0 : head_a;
  assign alu_b   = empty ? 32'h0 : head_b;
  assign alu_sel = empty ? 4'b0000 : head_sel;

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_tag   = res_tag_q;
  assign res_err   = res_err_q;
  assign busy      = !empty || (state_q != ST_IDLE);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {cmd_a, cmd_b, cmd_sel, cmd_tag};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    tag_lat_d   = tag_lat_q;
    ill_d       = ill_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    res_err_d   = res_err_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          tag_lat_d = head_tag;
          ill_d     = head_ill;
          state_d   = ST_CAPT;
        end
      end
      ST_CAPT: begin
        res_valid_d = 1'b1;
        res_data_d  = ill_q ? 32'h0 : alu_out;
        res_tag_d   = tag_lat_q;
        res_err_d   = ill_q;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (!empty) begin
            pop       = 1'b1;
            tag_lat_d = head_tag;
            ill_d     = head_ill;
            state_d   = ST_CAPT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      tag_lat_q   <= '0;
      ill_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= 32'h0;
      res_tag_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      tag_lat_q   <= tag_lat_d;
      ill_q       <= ill_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      res_err_q   <= res_err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu32_issue.sv
// +-----------------------------------------------------------------------+
// | tb_alu32_issue: directed bench for alu32_issue with a registered ALU   |
// | Rev 1.0  initial release                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_alu32_issue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [31:0]      cmd_a = '0;
  logic [31:0]      cmd_b = '0;
  logic [3:0]       cmd_sel = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [3:0]       alu_sel;
  logic [31:0]      alu_out;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;
  logic             busy;

  int   tests = 0;
  int   fails = 0;
  int   n_acc;
  int   wait_cyc;
  logic rdy;
  logic seen;

  alu32_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Downstream registered ALU; illegal selects yield a poison value.
  always_ff @(posedge clk) begin
    case (alu_sel)
      4'b0000: alu_out <= alu_a & alu_b;
      4'b0001: alu_out <= alu_a | alu_b;
      4'b0010: alu_out <= alu_a ^ alu_b;
      default: alu_out <= 32'hDEAD_BEEF;
    endcase
  end

  function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] s);
    case (s)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a ^ b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] q_a(input int i);
    return 32'h1357_9BDF ^ (32'(i) * 32'h0101_0101);
  endfunction
  function automatic logic [3:0] q_sel(input int i);
    return 4'((i + 1) % 3);
  endfunction
  function automatic logic [TAG_W-1:0] q_tag(input int i);
    return TAG_W'(i + 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                       input logic [TAG_W-1:0] t);
    cmd_a     = a;
    cmd_b     = b;
    cmd_sel   = s;
    cmd_tag   = t;
    cmd_valid = 1'b1;
  endtask

  task automatic run_one(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] s, input logic [TAG_W-1:0] t,
                         input logic [31:0] exp_d, input logic exp_e);
    drive(a, b, s, t);
    step();
    cmd_valid = 1'b0;
    step();
    chk({nm, "_capt_valid"}, 32'(res_valid), 32'd0);
    step();
    chk({nm, "_valid"}, 32'(res_valid), 32'd1);
    chk({nm, "_data"}, res_data, exp_d);
    chk({nm, "_tag"}, 32'(res_tag), 32'(t));
    chk({nm, "_err"}, 32'(res_err), 32'(exp_e));
    step();
    chk({nm, "_drop"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", res_data, 32'h0);
    chk("rst_tag", 32'(res_tag), 32'd0);
    chk("rst_err", 32'(res_err), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    step();
    step();
    #2 rst = 1'b0;
    step();

    // Single AND with two-edge latency.
    res_ready = 1'b1;
    drive(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, 4'd3);
    step();
    cmd_valid = 1'b0;
    chk("and_head_a", alu_a, 32'hF0F0_F0F0);
    chk("and_busy", 32'(busy), 32'd1);
    chk("and_e0_valid", 32'(res_valid), 32'd0);
    step();
    chk("and_e1_valid", 32'(res_valid), 32'd0);
    step();
    chk("and_e2_valid", 32'(res_valid), 32'd1);
    chk("and_data", res_data, 32'hF000_F000);
    chk("and_tag", 32'(res_tag), 32'd3);
    chk("and_err", 32'(res_err), 32'd0);
    step();
    chk("and_drop", 32'(res_valid), 32'd0);
    chk("and_idle_busy", 32'(busy), 32'd0);

    // Back-to-back OR then XOR.
    drive(32'h0000_00FF, 32'h0000_0F0F, 4'b0001, 4'd1);
    step();
    drive(32'h0000_00FF, 32'h0000_0F0F, 4'b0010, 4'd2);
    step();
    cmd_valid = 1'b0;
    chk("b2b_e1_valid", 32'(res_valid), 32'd0);
    step();
    chk("or_valid", 32'(res_valid), 32'd1);
    chk("or_data", res_data, 32'h0000_0FFF);
    chk("or_tag", 32'(res_tag), 32'd1);
    step();
    chk("b2b_gap", 32'(res_valid), 32'd0);
    step();
    chk("xor_valid", 32'(res_valid), 32'd1);
    chk("xor_data", res_data, 32'h0000_0FF0);
    chk("xor_tag", 32'(res_tag), 32'd2);
    step();
    chk("b2b_done", 32'(busy), 32'd0);

    // Backpressure: fill the FIFO behind a stalled result.
    res_ready = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      if (n_acc < DEPTH + 2) drive(q_a(n_acc), 32'h00FF_FF00, q_sel(n_acc), q_tag(n_acc));
      rdy = cmd_ready;
      step();
      if (cmd_valid && rdy) n_acc++;
    end
    chk("bp_accepted", 32'(n_acc), 32'(DEPTH + 1));
    chk("bp_full_ready", 32'(cmd_ready), 32'd0);
    chk("bp_hold_valid", 32'(res_valid), 32'd1);
    chk("bp_hold_data", res_data, ref_op(q_a(0), 32'h00FF_FF00, q_sel(0)));
    step();
    step();
    chk("bp_stable_data", res_data, ref_op(q_a(0), 32'h00FF_FF00, q_sel(0)));
    chk("bp_stable_tag", 32'(res_tag), 32'(q_tag(0)));
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) begin
      wait_cyc = 0;
      while (!res_valid && wait_cyc < 10) begin
        step();
        wait_cyc++;
      end
      chk("bp_wait", 32'(res_valid), 32'd1);
      chk("bp_order_data", res_data, ref_op(q_a(k), 32'h00FF_FF00, q_sel(k)));
      chk("bp_order_tag", 32'(res_tag), 32'(q_tag(k)));
      step();
    end
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (res_valid) seen = 1'b1;
      step();
    end
    chk("bp_no_extra", 32'(seen), 32'd0);
    chk("bp_drained_busy", 32'(busy), 32'd0);

    // Illegal select, then a legal one.
    run_one("ill", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0111, 4'd9, 32'h0, 1'b1);
    run_one("post_ill", 32'hFFFF_0000, 32'h0FF0_0FF0, 4'b0000, 4'd5, 32'h0FF0_0000, 1'b0);

    // Asynchronous reset while a result is held and two entries queued.
    res_ready = 1'b0;
    drive(32'h0000_000F, 32'h0000_00F0, 4'b0001, 4'd10);
    step();
    drive(32'h0000_000F, 32'h0000_00F0, 4'b0001, 4'd11);
    step();
    drive(32'h0000_000F, 32'h0000_00F0, 4'b0001, 4'd12);
    step();
    cmd_valid = 1'b0;
    step();
    chk("arst_pre_valid", 32'(res_valid), 32'd1);
    chk("arst_pre_full", 32'(cmd_ready), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(res_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(cmd_ready), 32'd1);
    chk("arst_data", res_data, 32'h0);
    step();
    #2 rst = 1'b0;
    res_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (res_valid) seen = 1'b1;
    end
    chk("arst_no_result", 32'(seen), 32'd0);
    chk("arst_idle_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
